spi_flash_arbiter: RTL and testbench
====================================

Name: spi_flash_arbiter

Overview:
Shares the single memory-mapped SPI flash reader between two requesters: port 0 (instruction fetch) and port 1 (data load).
- Latches one outstanding word-read per port.
- Arbitrates between ports and sequences the flash strobe/busy handshake.
- Returns the byte-order-corrected flash word to the requesting port.
- Sits between the CPU memory decode and the flash reader; the flash reader is unchanged.

Parameters:
ADDR_W, 20, word-address width (1M words of flash)
DATA_W, 32, read data width
PRIO_FIXED, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
p0_rstrb  in  1  port 0 read strobe, single-cycle pulse
p0_word_address  in  ADDR_W  port 0 word address, sampled with p0_rstrb
p0_rdata  out  DATA_W  port 0 read data, held until next port 0 completion
p0_rbusy  out  1  port 0 request outstanding
p1_rstrb  in  1  port 1 read strobe, single-cycle pulse
p1_word_address  in  ADDR_W  port 1 word address, sampled with p1_rstrb
p1_rdata  out  DATA_W  port 1 read data
p1_rbusy  out  1  port 1 request outstanding
flash_rstrb  out  1  strobe to flash reader
flash_word_address  out  ADDR_W  address to flash reader, stable from ISSUE through WAIT_DONE
flash_rdata  in  DATA_W  flash reader data
flash_rbusy  in  1  flash reader busy

Behaviour:
- Reset: the following outputs are 0 and registers cleared:
  - outputs: p0_rbusy, p1_rbusy, p0_rdata, p1_rdata, flash_rstrb, flash_word_address
  - pending bits cleared; state=IDLE; round-robin pointer=port 0
- Reset mid-operation aborts everything. No completion is reported.
- The flash reader is reset in parallel with this block, so no stale completion can arrive.
- Request capture:
  - pN_rstrb with pendN=0 → pendN<=1, addrN<=pN_word_address, pN_rbusy<=1 next cycle (T+1).
  - pN_rstrb while pendN=1 is a protocol violation: ignored; simulation assertion fires.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any pend is set and flash_rbusy=0, grant one port and load flash_word_address from that port's address register. Go to ISSUE.
  - If both ports are pending: round-robin grants the port not granted last; PRIO_FIXED=1 grants port 0.
  - A strobe arriving in the same cycle as a grant decision participates only from the next cycle.
- ISSUE: flash_rstrb=1. Go to WAIT_BUSY.
- WAIT_BUSY:
  - flash_rstrb stays 1 until flash_rbusy=1 is observed, which tolerates the flash reader's post-reset START cycle.
  - When flash_rbusy=1: flash_rstrb<=0, go to WAIT_DONE.
- WAIT_DONE:
  - On flash_rbusy=0: pN_rdata<=flash_rdata, pendN<=0, pN_rbusy<=0 (both at C+1, where C is the cycle the fall is observed).
  - Update round-robin pointer. Return to IDLE.
- Back-to-back: the other port's pending request is granted in the IDLE cycle immediately following completion.
- Latency overhead, uncontended, flash idle: strobe at T → flash_rstrb at T+2 (capture cycle, then ISSUE). Total overhead is 3 cycles plus the flash transaction.
- pN_rdata is unchanged by the other port's completions.

Optional Feature:
Macro FLASH_ARB_CACHE_EN.
- Defined:
  - Adds a single-entry read cache (valid bit, ADDR_W tag, DATA_W data); invalidated on reset.
  - Filled on every flash completion.
  - In IDLE, a granted request whose address matches the valid tag completes without touching the flash: pN_rdata updated and pN_rbusy low at T+2, no flash_rstrb.
  - Flash is read-only, so no invalidation path is needed.
- Undefined: no cache storage; every request goes to the flash.

Decomposition:
- Package spi_flash_arb_pkg holds:
  - state enum (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE)
  - port index constants PORT_IFETCH=0, PORT_DATA=1
  - FLASH_ADDR_W=20, FLASH_DATA_W=32
- One sub-module, spi_flash_arb_rr2: a two-way round-robin/fixed grant with last-grant pointer update input.

Test Plan:
1. Single fetch: p0_rstrb with addr 0x00010. Model flash answers 0xDEADBEEF after 70 cycles busy → p0_rbusy high 1..completion, p0_rdata=0xDEADBEEF, exactly one flash_rstrb episode, p1 untouched.
2. Simultaneous strobes: p0 addr 0x00004 and p1 addr 0x00100 in the same cycle, round-robin from reset → port 0 served first, port 1 flash_rstrb in the IDLE cycle after p0 completion. Repeat: port 1 served first.
3. PRIO_FIXED=1: p1 pending, then p0 and p1 pending together repeatedly → port 0 always granted first; no starvation check beyond per-test completion.
4. Post-reset START: model flash holds rbusy=0 and ignores strobe for 1 cycle → flash_rstrb held high until rbusy rises; single read issued, correct data returned.
5. Reset mid-WAIT_DONE: assert reset for 1 cycle → all outputs 0, pend cleared. A new p1 request afterwards completes normally.
6. (FLASH_ARB_CACHE_EN) Read 0x00020 twice → second completes at T+2 with the same data and no flash_rstrb. Read 0x00021 → flash accessed.

Source files
------------

// File: rtl/spi_flash_arb_pkg.sv
// Shared types and constants for the SPI flash arbiter: FSM state encoding,
// requester port indices and the default flash geometry.
package spi_flash_arb_pkg;

    localparam int FLASH_ADDR_W = 20;
    localparam int FLASH_DATA_W = 32;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_e;

endpackage

// File: rtl/spi_flash_arb_rr2.sv
// Two-way grant: round-robin on a last-served pointer, or port 0 always wins ties.
// Latency: combinational grant; pointer moves one cycle after upd_vld.
// Backpressure: none; the grant is only consumed when the arbiter FSM is idle.
module spi_flash_arb_rr2
    import spi_flash_arb_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd_vld,
    input  logic       upd_port,
    output logic       gnt_vld,
    output logic       gnt_port
);

    // prio_q is the port that wins the next tie
    logic prio_q, prio_d;

    always_comb begin
        prio_d = prio_q;
        if (upd_vld) begin
            prio_d = ~upd_port;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= PORT_IFETCH;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        gnt_vld  = |req;
        gnt_port = PORT_IFETCH;
        if (req == 2'b11) begin
            gnt_port = (PRIO_FIXED != 0) ? PORT_IFETCH : prio_q;
        end else if (req[PORT_DATA]) begin
            gnt_port = PORT_DATA;
        end
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash reader between ifetch (port 0) and data load (port 1); FLASH_ARB_CACHE_EN adds a one-entry cache.
// Latency: strobe at T -> flash_rstrb at T+2, 3 cycles of overhead on the flash transaction; cache hit completes at T+2.
// Backpressure: one outstanding read per port, signalled by pN_rbusy; a strobe while busy is dropped.
module spi_flash_arbiter
    import spi_flash_arb_pkg::*;
#(
    parameter int ADDR_W     = FLASH_ADDR_W,
    parameter int DATA_W     = FLASH_DATA_W,
    parameter int PRIO_FIXED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_rstrb,
    input  logic [ADDR_W-1:0] p0_word_address,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rbusy,
    input  logic              p1_rstrb,
    input  logic [ADDR_W-1:0] p1_word_address,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rbusy,
    output logic              flash_rstrb,
    output logic [ADDR_W-1:0] flash_word_address,
    input  logic [DATA_W-1:0] flash_rdata,
    input  logic              flash_rbusy
);

    arb_state_e             state_q, state_d;
    logic [1:0]             pend_q, pend_d;
    logic [1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
    logic                   gnt_q, gnt_d;
    logic [ADDR_W-1:0]      flash_addr_q, flash_addr_d;
    logic [1:0]             rstrb;
    logic [1:0][ADDR_W-1:0] waddr;
    logic                   arb_vld, arb_port, upd_vld, upd_port;
`ifdef FLASH_ARB_CACHE_EN
    logic                   cache_vld_q, cache_vld_d;
    logic [ADDR_W-1:0]      cache_tag_q, cache_tag_d;
    logic [DATA_W-1:0]      cache_dat_q, cache_dat_d;
`endif

    assign rstrb = {p1_rstrb, p0_rstrb};
    assign waddr = {p1_word_address, p0_word_address};

    spi_flash_arb_rr2 #(.PRIO_FIXED(PRIO_FIXED)) u_rr2 (
        .clk      (clk),
        .reset    (reset),
        .req      (pend_q),
        .upd_vld  (upd_vld),
        .upd_port (upd_port),
        .gnt_vld  (arb_vld),
        .gnt_port (arb_port)
    );

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        gnt_d        = gnt_q;
        flash_addr_d = flash_addr_q;
        upd_vld      = 1'b0;
        upd_port     = gnt_q;
`ifdef FLASH_ARB_CACHE_EN
        cache_vld_d  = cache_vld_q;
        cache_tag_d  = cache_tag_q;
        cache_dat_d  = cache_dat_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_vld && !flash_rbusy) begin
                    gnt_d        = arb_port;
                    flash_addr_d = addr_q[arb_port];
                    state_d      = ISSUE;
`ifdef FLASH_ARB_CACHE_EN
                    if (cache_vld_q && (cache_tag_q == addr_q[arb_port])) begin
                        rdata_d[arb_port] = cache_dat_q;
                        pend_d[arb_port]  = 1'b0;
                        upd_vld           = 1'b1;
                        upd_port          = arb_port;
                        flash_addr_d      = flash_addr_q;
                        state_d           = IDLE;
                    end
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            // strobe is held until busy is seen, covering the reader's start-up cycle
            WAIT_BUSY: begin
                if (flash_rbusy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!flash_rbusy) begin
                    rdata_d[gnt_q] = flash_rdata;
                    pend_d[gnt_q]  = 1'b0;
                    upd_vld        = 1'b1;
                    state_d        = IDLE;
`ifdef FLASH_ARB_CACHE_EN
                    cache_vld_d    = 1'b1;
                    cache_tag_d    = flash_addr_q;
                    cache_dat_d    = flash_rdata;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        for (int i = 0; i < 2; i++) begin
            if (rstrb[i] && !pend_q[i]) begin
                pend_d[i] = 1'b1;
                addr_d[i] = waddr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            addr_q       <= '0;
            rdata_q      <= '0;
            gnt_q        <= PORT_IFETCH;
            flash_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            gnt_q        <= gnt_d;
            flash_addr_q <= flash_addr_d;
        end
    end

`ifdef FLASH_ARB_CACHE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_vld_q <= 1'b0;
            cache_tag_q <= '0;
            cache_dat_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_tag_q <= cache_tag_d;
            cache_dat_q <= cache_dat_d;
        end
    end
`endif

    assign p0_rdata           = rdata_q[PORT_IFETCH];
    assign p1_rdata           = rdata_q[PORT_DATA];
    assign p0_rbusy           = pend_q[PORT_IFETCH];
    assign p1_rbusy           = pend_q[PORT_DATA];
    assign flash_rstrb        = (state_q == ISSUE) || (state_q == WAIT_BUSY);
    assign flash_word_address = flash_addr_q;

    p0_strobe_while_pending: assert property (@(posedge clk) disable iff (reset)
        !(p0_rstrb && pend_q[PORT_IFETCH]));
    p1_strobe_while_pending: assert property (@(posedge clk) disable iff (reset)
        !(p1_rstrb && pend_q[PORT_DATA]));

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: instance 0 round-robin, instance 1 fixed priority, each with a flash reader model.
// Expected completions are queued in expected order and matched against observed rbusy falls.
module tb_spi_flash_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       p0_rstrb, p1_rstrb, p0_rbusy, p1_rbusy, fl_rstrb, f_busy;
    logic [1:0][19:0] p0_addr, p1_addr, fl_addr, f_addr;
    logic [1:0][31:0] p0_rdata, p1_rdata, f_rd;

    int f_lat, f_skip_cfg;
    int f_cnt[2], f_skip[2], f_starts[2];

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int   total = 0, bad = 0, cyc = 0;
    int   episodes[2], cmpl_cyc[2][2];
    logic prev_busy[2][2];
    logic prev_rs[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_flash_arbiter #(.ADDR_W(20), .DATA_W(32), .PRIO_FIXED(g)) u_dut (
            .clk                (clk),
            .reset              (reset),
            .p0_rstrb           (p0_rstrb[g]),
            .p0_word_address    (p0_addr[g]),
            .p0_rdata           (p0_rdata[g]),
            .p0_rbusy           (p0_rbusy[g]),
            .p1_rstrb           (p1_rstrb[g]),
            .p1_word_address    (p1_addr[g]),
            .p1_rdata           (p1_rdata[g]),
            .p1_rbusy           (p1_rbusy[g]),
            .flash_rstrb        (fl_rstrb[g]),
            .flash_word_address (fl_addr[g]),
            .flash_rdata        (f_rd[g]),
            .flash_rbusy        (f_busy[g])
        );
    end

    function automatic logic [31:0] fw(input logic [19:0] a);
        if (a == 20'h00010) return 32'hDEADBEEF;
        return 32'hC0DE_0000 ^ {12'h000, a} ^ {a[7:0], 24'h000000};
    endfunction

    // flash reader model: ignores strobes while busy and for f_skip strobe cycles after reset
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                f_busy[i] <= 1'b0;
                f_cnt[i]  <= 0;
                f_skip[i] <= f_skip_cfg;
                f_rd[i]   <= '0;
            end else if (f_busy[i]) begin
                if (f_cnt[i] == 0) begin
                    f_busy[i] <= 1'b0;
                    f_rd[i]   <= fw(f_addr[i]);
                end else begin
                    f_cnt[i] <= f_cnt[i] - 1;
                end
            end else if (fl_rstrb[i]) begin
                if (f_skip[i] != 0) begin
                    f_skip[i] <= f_skip[i] - 1;
                end else begin
                    f_busy[i]   <= 1'b1;
                    f_cnt[i]    <= f_lat;
                    f_addr[i]   <= fl_addr[i];
                    f_starts[i] <= f_starts[i] + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic        b;
        logic [31:0] d;
        exp_t        e;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (fl_rstrb[i] && !prev_rs[i]) episodes[i]++;
            prev_rs[i] = fl_rstrb[i];
            for (int p = 0; p < 2; p++) begin
                b = (p == 0) ? p0_rbusy[i] : p1_rbusy[i];
                d = (p == 0) ? p0_rdata[i] : p1_rdata[i];
                if (prev_busy[i][p] && !b && !reset) begin
                    cmpl_cyc[i][p] = cyc;
                    if (sb.size() == 0) begin
                        check("unexpected_cmpl", 64'(i * 2 + p), 64'hFF);
                    end else begin
                        e = sb.pop_front();
                        check("cmpl_src", 64'(i * 2 + p), 64'(e.inst * 2 + e.port));
                        check("cmpl_data", 64'(d), 64'(e.data));
                    end
                end
                prev_busy[i][p] = b;
            end
        end
    endtask

    task automatic req(input int i, input int p, input logic [19:0] a);
        exp_t e;
        if (p == 0) begin
            p0_rstrb[i] = 1'b1;
            p0_addr[i]  = a;
        end else begin
            p1_rstrb[i] = 1'b1;
            p1_addr[i]  = a;
        end
        e.inst = i;
        e.port = p;
        e.data = fw(a);
        sb.push_back(e);
    endtask

    task automatic clr();
        p0_rstrb = '0;
        p1_rstrb = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || p0_rbusy != 0 || p1_rbusy != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag, input int i);
        check({tag, "_p0_rbusy"}, 64'(p0_rbusy[i]), 64'd0);
        check({tag, "_p1_rbusy"}, 64'(p1_rbusy[i]), 64'd0);
        check({tag, "_p0_rdata"}, 64'(p0_rdata[i]), 64'd0);
        check({tag, "_p1_rdata"}, 64'(p1_rdata[i]), 64'd0);
        check({tag, "_frstrb"}, 64'(fl_rstrb[i]), 64'd0);
        check({tag, "_faddr"}, 64'(fl_addr[i]), 64'd0);
    endtask

    initial begin
        int t0, ep, st;
        reset      = 1'b1;
        p0_rstrb   = '0;
        p1_rstrb   = '0;
        p0_addr    = '0;
        p1_addr    = '0;
        f_lat      = 5;
        f_skip_cfg = 0;
        for (int i = 0; i < 2; i++) begin
            episodes[i] = 0;
            f_starts[i] = 0;
            prev_rs[i]  = 1'b0;
            for (int p = 0; p < 2; p++) begin
                prev_busy[i][p] = 1'b0;
                cmpl_cyc[i][p]  = 0;
            end
        end
        repeat (3) tick();
        check_zero("rst0", 0);
        check_zero("rst1", 1);
        reset = 1'b0;

        // single fetch with a slow flash
        f_lat = 70;
        ep = episodes[0];
        st = f_starts[0];
        req(0, 0, 20'h00010);
        t0 = cyc;
        tick();
        clr();
        check("t1_rbusy", 64'(p0_rbusy[0]), 64'd1);
        check("t1_frstrb_early", 64'(fl_rstrb[0]), 64'd0);
        tick();
        check("t1_frstrb", 64'(fl_rstrb[0]), 64'd1);
        check("t1_faddr", 64'(fl_addr[0]), 64'h00010);
        wait_idle(200);
        check("t1_lat", 64'(cmpl_cyc[0][0] - t0), 64'(f_lat + 5));
        check("t1_rdata", 64'(p0_rdata[0]), 64'hDEADBEEF);
        check("t1_episodes", 64'(episodes[0] - ep), 64'd1);
        check("t1_starts", 64'(f_starts[0] - st), 64'd1);
        check("t1_p1_rdata", 64'(p1_rdata[0]), 64'd0);

        // simultaneous strobes, round-robin from reset: port 0 first
        do_reset();
        f_lat = 5;
        req(0, 0, 20'h00004);
        req(0, 1, 20'h00100);
        tick();
        clr();
        wait_idle(100);
        check("t2_gap", 64'(cmpl_cyc[0][1] - cmpl_cyc[0][0]), 64'(f_lat + 4));
        // a lone port 0 read leaves port 1 owed the next tie
        req(0, 0, 20'h00008);
        tick();
        clr();
        wait_idle(100);
        req(0, 1, 20'h00104);
        req(0, 0, 20'h0000C);
        tick();
        clr();
        wait_idle(100);
        check("t2r_gap", 64'(cmpl_cyc[0][0] - cmpl_cyc[0][1]), 64'(f_lat + 4));
        check("t2r_p1_rdata", 64'(p1_rdata[0]), 64'(fw(20'h00104)));

        // fixed priority: port 0 wins every tie, even right after being served
        for (int r = 0; r < 3; r++) begin
            req(1, 0, 20'h00200 + 20'(r * 16));
            tick();
            clr();
            wait_idle(100);
            req(1, 0, 20'h00204 + 20'(r * 16));
            req(1, 1, 20'h00208 + 20'(r * 16));
            tick();
            clr();
            wait_idle(100);
            check("t3_gap", 64'(cmpl_cyc[1][1] - cmpl_cyc[1][0]), 64'(f_lat + 4));
        end

        // reader ignores the first strobe after reset
        f_skip_cfg = 1;
        do_reset();
        f_skip_cfg = 0;
        ep = episodes[0];
        st = f_starts[0];
        req(0, 1, 20'h00300);
        t0 = cyc;
        tick();
        clr();
        tick();
        check("t4_frstrb", 64'(fl_rstrb[0]), 64'd1);
        tick();
        check("t4_hold", 64'(fl_rstrb[0]), 64'd1);
        wait_idle(100);
        check("t4_lat", 64'(cmpl_cyc[0][1] - t0), 64'(f_lat + 6));
        check("t4_episodes", 64'(episodes[0] - ep), 64'd1);
        check("t4_starts", 64'(f_starts[0] - st), 64'd1);

        // reset while waiting on the flash aborts the read
        f_lat = 20;
        req(0, 0, 20'h00030);
        tick();
        clr();
        repeat (10) tick();
        check("t5_busy_pre", 64'(p0_rbusy[0]), 64'd1);
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        check_zero("t5", 0);
        f_lat = 5;
        req(0, 1, 20'h00040);
        tick();
        clr();
        wait_idle(100);
        check("t5_p1_rdata", 64'(p1_rdata[0]), 64'(fw(20'h00040)));
        check("t5_p0_rbusy", 64'(p0_rbusy[0]), 64'd0);

`ifdef FLASH_ARB_CACHE_EN
        do_reset();
        req(0, 0, 20'h00020);
        tick();
        clr();
        wait_idle(100);
        ep = episodes[0];
        req(0, 0, 20'h00020);
        t0 = cyc;
        tick();
        clr();
        wait_idle(100);
        check("t6_hit_lat", 64'(cmpl_cyc[0][0] - t0), 64'd2);
        check("t6_hit_episodes", 64'(episodes[0] - ep), 64'd0);
        req(0, 1, 20'h00021);
        tick();
        clr();
        wait_idle(100);
        check("t6_miss_episodes", 64'(episodes[0] - ep), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
